// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl
// ---------------
// Game-step scheduler and snake-body controller.
//
// Every FRAMES_PER_STEP frame_start pulses the controller runs one
// movement step:
//   1. CALC: latch the direction and build the head candidate.
//   2. Bounds and wall test on the candidate.
//   3. CHECK: self-collision test, one segment per cycle.
//   4. COMMIT: shift the body, apply growth and score.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   frame_start         one-cycle strobe per video frame
//   start               level; starts/restarts a game from IDLE/LOSE/WIN
//   btn_dir[3:0]        {up,down,left,right}, one-hot, other codes ignored
//   applepos_x/y        apple cell top-left corner
//   wallpos_x/y         wall cell top-left corner
//   snakepos_x/y        packed body, segment i at [i*COORD_W +: COORD_W],
//                       segment 0 is the head
//   length, points      active segments, apples eaten this game
//   apple_eaten         high for the single COMMIT cycle of a growing step
//   lose, win           sticky game result, cleared by start
//   busy                high in CHECK and COMMIT
//   dbg_state           current FSM state encoding
//
// Interface timing: there is no valid/ready handshake. Strobes and levels
// are sampled on every rising edge, and outputs change only on rising edges.
//
// Build option: define SNAKE_WRAP_EN to make the head wrap to the opposite
// edge instead of losing when it leaves the playfield.

module snake_step_ctrl #(
    parameter int MAX_SEG         = 23,
    parameter int COORD_W         = 11,
    parameter int SEG_SIZE        = 32,
    parameter int SCREEN_WIDTH    = 1440,
    parameter int SCREEN_HEIGHT   = 900,
    parameter int FRAMES_PER_STEP = 8,
    parameter int START_LEN       = 3,
    parameter int WIN_LEN         = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       start,
    input  logic [3:0]                 btn_dir,
    input  logic [COORD_W-1:0]         applepos_x,
    input  logic [COORD_W-1:0]         applepos_y,
    input  logic [COORD_W-1:0]         wallpos_x,
    input  logic [COORD_W-1:0]         wallpos_y,
    output logic [MAX_SEG*COORD_W-1:0] snakepos_x,
    output logic [MAX_SEG*COORD_W-1:0] snakepos_y,
    output logic [5:0]                 length,
    output logic [5:0]                 points,
    output logic                       apple_eaten,
    output logic                       lose,
    output logic                       win,
    output logic                       busy,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_CALC   = 3'd2,
        S_CHECK  = 3'd3,
        S_COMMIT = 3'd4,
        S_LOSE   = 3'd5,
        S_WIN    = 3'd6
    } state_t;

    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int IW  = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

    localparam logic [FCW-1:0]   FC_LAST = FCW'(FRAMES_PER_STEP - 1);
    localparam logic [COORD_W:0] SEG_W   = (COORD_W+1)'(SEG_SIZE);
    localparam logic [COORD_W:0] X_MAX   = (COORD_W+1)'(SCREEN_WIDTH - SEG_SIZE);
    localparam logic [COORD_W:0] Y_MAX   = (COORD_W+1)'(SCREEN_HEIGHT - SEG_SIZE);
    localparam logic [3:0]       DIR_RIGHT = 4'b0001;

    state_t               state, state_nxt;
    logic [COORD_W-1:0]   seg_x [MAX_SEG];
    logic [COORD_W-1:0]   seg_y [MAX_SEG];
    logic [5:0]           len_q, pts_q, len_nxt;
    logic [3:0]           dir_q, pend_q, dir_opp, dir_sel;
    logic [FCW-1:0]       fcnt;
    logic [COORD_W-1:0]   cand_x, cand_y;
    logic                 grow_q;
    logic [IW-1:0]        idx_q;

    logic                 btn_valid, game_start;
    logic [COORD_W:0]     nx_w, ny_w;
    logic                 under_x, under_y, over_x, over_y;
    logic [COORD_W-1:0]   cx, cy;
    logic                 oob, hit_wall, grow_c;
    logic [5:0]           chk_last;
    logic                 no_chk, seg_hit;

    assign btn_valid  = (btn_dir != 4'b0) && ((btn_dir & (btn_dir - 4'd1)) == 4'b0);
    assign game_start = start && (state == S_IDLE || state == S_LOSE || state == S_WIN);

    // A reversal straight into the neck is discarded; keep moving as before.
    assign dir_opp = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    assign dir_sel = (pend_q == dir_opp) ? dir_q : pend_q;

    // Candidate head computed one bit wider so both underflow and overflow
    // are visible before truncation.
    always_comb begin
        nx_w    = {1'b0, seg_x[0]};
        ny_w    = {1'b0, seg_y[0]};
        under_x = 1'b0;
        under_y = 1'b0;
        if (dir_sel[0]) begin
            nx_w = {1'b0, seg_x[0]} + SEG_W;
        end else if (dir_sel[1]) begin
            under_x = ({1'b0, seg_x[0]} < SEG_W);
            nx_w    = {1'b0, seg_x[0]} - SEG_W;
        end else if (dir_sel[2]) begin
            ny_w = {1'b0, seg_y[0]} + SEG_W;
        end else if (dir_sel[3]) begin
            under_y = ({1'b0, seg_y[0]} < SEG_W);
            ny_w    = {1'b0, seg_y[0]} - SEG_W;
        end
    end

    assign over_x = !under_x && (nx_w > X_MAX);
    assign over_y = !under_y && (ny_w > Y_MAX);

`ifdef SNAKE_WRAP_EN
    assign cx  = under_x ? X_MAX[COORD_W-1:0] : (over_x ? '0 : nx_w[COORD_W-1:0]);
    assign cy  = under_y ? Y_MAX[COORD_W-1:0] : (over_y ? '0 : ny_w[COORD_W-1:0]);
    assign oob = 1'b0;
`else
    assign cx  = nx_w[COORD_W-1:0];
    assign cy  = ny_w[COORD_W-1:0];
    assign oob = under_x | under_y | over_x | over_y;
`endif

    assign hit_wall = (cx == wallpos_x) && (cy == wallpos_y);
    assign grow_c   = (cx == applepos_x) && (cy == applepos_y);

    // On a non-growing step the tail moves away, so it is not a collision.
    assign chk_last = grow_q ? (len_q - 6'd1) : (len_q - 6'd2);
    assign no_chk   = !grow_q && (len_q == 6'd1);
    assign seg_hit  = (seg_x[idx_q] == cand_x) && (seg_y[idx_q] == cand_y);
    assign len_nxt  = (grow_q && (len_q < 6'(MAX_SEG))) ? (len_q + 6'd1) : len_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_RUN;
            S_RUN:    if (frame_start && (fcnt == FC_LAST)) state_nxt = S_CALC;
            S_CALC:   state_nxt = (oob || hit_wall) ? S_LOSE : S_CHECK;
            S_CHECK: begin
                if (no_chk)                         state_nxt = S_COMMIT;
                else if (seg_hit)                   state_nxt = S_LOSE;
                else if (6'(idx_q) == chk_last)     state_nxt = S_COMMIT;
            end
            S_COMMIT: state_nxt = (len_nxt == 6'(WIN_LEN)) ? S_WIN : S_RUN;
            S_LOSE:   if (start) state_nxt = S_RUN;
            S_WIN:    if (start) state_nxt = S_RUN;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Pending direction follows the buttons in every state; last valid wins.
    always_ff @(posedge clk) begin
        if (rst)            pend_q <= DIR_RIGHT;
        else if (btn_valid) pend_q <= btn_dir;
        else if (game_start) pend_q <= DIR_RIGHT;
    end

    always_ff @(posedge clk) begin
        if (rst || game_start) begin
            for (int i = 0; i < MAX_SEG; i++) begin
                seg_x[i] <= (i < START_LEN) ? COORD_W'(640 - i * SEG_SIZE) : '0;
                seg_y[i] <= (i < START_LEN) ? COORD_W'(448) : '0;
            end
            len_q  <= 6'(START_LEN);
            pts_q  <= 6'd0;
            dir_q  <= DIR_RIGHT;
            fcnt   <= '0;
            cand_x <= '0;
            cand_y <= '0;
            grow_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (frame_start) fcnt <= (fcnt == FC_LAST) ? '0 : fcnt + 1'b1;
                end
                S_CALC: begin
                    dir_q  <= dir_sel;
                    cand_x <= cx;
                    cand_y <= cy;
                    grow_q <= grow_c;
                    idx_q  <= '0;
                end
                S_CHECK: idx_q <= idx_q + 1'b1;
                S_COMMIT: begin
                    for (int i = MAX_SEG - 1; i > 0; i--) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= cand_x;
                    seg_y[0] <= cand_y;
                    len_q    <= len_nxt;
                    if (grow_q && (pts_q != 6'd63)) pts_q <= pts_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_SEG; g++) begin : g_pack
        assign snakepos_x[g*COORD_W +: COORD_W] = seg_x[g];
        assign snakepos_y[g*COORD_W +: COORD_W] = seg_y[g];
    end

    assign length      = len_q;
    assign points      = pts_q;
    assign apple_eaten = (state == S_COMMIT) && grow_q;
    assign lose        = (state == S_LOSE);
    assign win         = (state == S_WIN);
    assign busy        = (state == S_CHECK) || (state == S_COMMIT);
    assign dbg_state   = state;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Bench for snake_step_ctrl: a game-level model predicts each step, the
// expected outcome is queued when the step is driven and compared when the
// DUT finishes the step.

module tb_snake_step_ctrl;

    localparam int MAX_SEG = 23;
    localparam int CW      = 11;
    localparam int SEG     = 32;
    localparam int SW      = 1440;
    localparam int SH      = 900;
    localparam int WIN_LEN = 23;
    localparam int W       = 77;

    logic                    clk = 1'b0;
    logic                    rst, frame_start, start;
    logic [3:0]              btn_dir;
    logic [CW-1:0]           applepos_x, applepos_y, wallpos_x, wallpos_y;
    logic [MAX_SEG*CW-1:0]   snakepos_x, snakepos_y;
    logic [5:0]              length, points;
    logic                    apple_eaten, lose, win, busy;
    logic [2:0]              dbg_state;

    snake_step_ctrl dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .start(start),
        .btn_dir(btn_dir),
        .applepos_x(applepos_x), .applepos_y(applepos_y),
        .wallpos_x(wallpos_x), .wallpos_y(wallpos_y),
        .snakepos_x(snakepos_x), .snakepos_y(snakepos_y),
        .length(length), .points(points), .apple_eaten(apple_eaten),
        .lose(lose), .win(win), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [W-1:0] exp_q[$];

    // game model; direction 0=right 1=left 2=down 3=up
    int m_x[MAX_SEG];
    int m_y[MAX_SEG];
    int m_len, m_pts, m_dir, m_pend;
    bit m_lost, m_won;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int seg_x_of(input int i);
        return int'(snakepos_x[i*CW +: CW]);
    endfunction

    function automatic int seg_y_of(input int i);
        return int'(snakepos_y[i*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAX_SEG; i++) begin
            m_x[i] = (i < 3) ? 640 - i * SEG : 0;
            m_y[i] = (i < 3) ? 448 : 0;
        end
        m_len = 3; m_pts = 0; m_dir = 0; m_pend = 0;
        m_lost = 0; m_won = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_frames(input int n);
        for (int p = 0; p < n; p++) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset();
    endtask

    task automatic run_step(input logic [3:0] btn, input int ax, input int ay,
                            input int wx, input int wy);
        int cx, cy, last, hit, bexp, aexp, bc, ac, tidx;
        bit oob, grow, seen, done;
        logic [W-1:0] e;

        btn_dir = btn;
        applepos_x = CW'(ax); applepos_y = CW'(ay);
        wallpos_x  = CW'(wx); wallpos_y  = CW'(wy);
        @(negedge clk);
        btn_dir = 4'b0;

        // model
        case (btn)
            4'b0001: m_pend = 0;
            4'b0010: m_pend = 1;
            4'b0100: m_pend = 2;
            4'b1000: m_pend = 3;
            default: ;
        endcase
        if ((m_pend ^ 1) != m_dir) m_dir = m_pend;
        cx = m_x[0] + ((m_dir == 0) ? SEG : (m_dir == 1) ? -SEG : 0);
        cy = m_y[0] + ((m_dir == 2) ? SEG : (m_dir == 3) ? -SEG : 0);
        oob = (cx < 0) || (cx > SW - SEG) || (cy < 0) || (cy > SH - SEG);
`ifdef SNAKE_WRAP_EN
        if (cx < 0) cx = SW - SEG; else if (cx > SW - SEG) cx = 0;
        if (cy < 0) cy = SH - SEG; else if (cy > SH - SEG) cy = 0;
        oob = 0;
`endif
        grow = (cx == ax) && (cy == ay);
        bexp = 0; aexp = 0;
        if (oob || (cx == wx && cy == wy)) begin
            m_lost = 1;
        end else begin
            last = grow ? m_len - 1 : m_len - 2;
            hit = -1;
            for (int k = 0; k <= last; k++)
                if (hit < 0 && m_x[k] == cx && m_y[k] == cy) hit = k;
            if (hit >= 0) begin
                m_lost = 1;
                bexp = hit + 1;
            end else begin
                bexp = ((last < 0) ? 1 : last + 1) + 1;
                for (int i = MAX_SEG - 1; i > 0; i--) begin
                    m_x[i] = m_x[i-1];
                    m_y[i] = m_y[i-1];
                end
                m_x[0] = cx; m_y[0] = cy;
                if (grow) begin
                    if (m_len < MAX_SEG) m_len++;
                    if (m_pts < 63) m_pts++;
                    aexp = 1;
                end
                if (m_len == WIN_LEN) m_won = 1;
            end
        end
        exp_q.push_back({6'(bexp), 2'(aexp), 11'(m_x[0]), 11'(m_y[0]), 11'(m_x[1]),
                         11'(m_x[m_len-1]), 11'(m_y[m_len-1]), 6'(m_len), 6'(m_pts),
                         m_lost, m_won});

        // frame pulses; the last one launches the step
        pulse_frames(7);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;

        seen = 0; done = 0; bc = 0; ac = 0;
        for (int t = 0; t < 60 && !done; t++) begin
            if (busy) begin bc++; seen = 1; end
            if (apple_eaten) ac++;
            if ((seen && !busy) || lose || win) done = 1;
            else @(negedge clk);
        end
        if (!done) check_val("step_timeout", 64'd0, 64'd1);

        e = exp_q.pop_front();
        tidx = int'(e[13:8]) - 1;
        check_val("busy_cycles", 64'(bc), 64'(e[76:71]));
        check_val("apple_pulses", 64'(ac), 64'(e[70:69]));
        check_val("head_x", 64'(seg_x_of(0)), 64'(e[68:58]));
        check_val("head_y", 64'(seg_y_of(0)), 64'(e[57:47]));
        check_val("seg1_x", 64'(seg_x_of(1)), 64'(e[46:36]));
        check_val("tail_x", 64'(seg_x_of(tidx)), 64'(e[35:25]));
        check_val("tail_y", 64'(seg_y_of(tidx)), 64'(e[24:14]));
        check_val("length", 64'(length), 64'(e[13:8]));
        check_val("points", 64'(points), 64'(e[7:2]));
        check_val("lose", 64'(lose), 64'(e[1]));
        check_val("win", 64'(win), 64'(e[0]));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_len"},   64'(length), 64'd3);
        check_val({pfx, "_pts"},   64'(points), 64'd0);
        check_val({pfx, "_lose"},  64'(lose), 64'd0);
        check_val({pfx, "_win"},   64'(win), 64'd0);
        check_val({pfx, "_busy"},  64'(busy), 64'd0);
        check_val({pfx, "_apple"}, 64'(apple_eaten), 64'd0);
        check_val({pfx, "_state"}, 64'(dbg_state), 64'd0);
        check_val({pfx, "_hx"},    64'(seg_x_of(0)), 64'd640);
        check_val({pfx, "_hy"},    64'(seg_y_of(0)), 64'd448);
        check_val({pfx, "_s1x"},   64'(seg_x_of(1)), 64'd608);
        check_val({pfx, "_s2x"},   64'(seg_x_of(2)), 64'd576);
        check_val({pfx, "_s3x"},   64'(seg_x_of(3)), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; frame_start = 1'b0; start = 1'b0; btn_dir = 4'b0;
        applepos_x = '0; applepos_y = '0; wallpos_x = '0; wallpos_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs("rst");

        // frames in IDLE do nothing
        pulse_frames(10);
        check_val("idle_hx", 64'(seg_x_of(0)), 64'd640);
        check_val("idle_state", 64'(dbg_state), 64'd0);

        start_game();
        // basic moves, reversal ignored, turn up
        run_step(4'b0000, 0, 0, 1408, 32);
        run_step(4'b0010, 0, 0, 1408, 32);
        run_step(4'b1000, 0, 0, 1408, 32);
        // eat, then square walk where the head enters the vacating tail
        run_step(4'b0001, 736, 416, 1408, 32);
        run_step(4'b0100, 0, 0, 1408, 32);
        run_step(4'b0010, 0, 0, 1408, 32);
        run_step(4'b0000, 672, 448, 1408, 32);
        // coil into segment 3
        run_step(4'b1000, 0, 0, 1408, 32);
        run_step(4'b0001, 0, 0, 1408, 32);
        run_step(4'b0100, 0, 0, 1408, 32);

        // LOSE holds everything
        pulse_frames(16);
        check_val("hold_lose", 64'(lose), 64'd1);
        check_val("hold_hx", 64'(seg_x_of(0)), 64'(m_x[0]));
        check_val("hold_len", 64'(length), 64'(m_len));
        check_val("hold_busy", 64'(busy), 64'd0);

        start_game();
        check_val("restart_len", 64'(length), 64'd3);
        check_val("restart_pts", 64'(points), 64'd0);
        check_val("restart_lose", 64'(lose), 64'd0);
        check_val("restart_hx", 64'(seg_x_of(0)), 64'd640);

        // right edge: non one-hot button first, then run into the boundary
        run_step(4'b1010, 0, 0, 1408, 32);
        for (int s = 0; s < 24; s++) run_step(4'b0000, 0, 0, 1408, 32);

        // wall directly ahead
        start_game();
        run_step(4'b0000, 0, 0, 672, 448);

        // grow to WIN_LEN by eating the cell ahead each step
        start_game();
        for (int s = 0; s < WIN_LEN - 3; s++) run_step(4'b0000, m_x[0] + SEG, 448, 1408, 32);
        pulse_frames(16);
        check_val("hold_win", 64'(win), 64'd1);
        check_val("hold_win_len", 64'(length), 64'(WIN_LEN));
        check_val("hold_win_pts", 64'(points), 64'(WIN_LEN - 3));

        // reset during CHECK
        start_game();
        pulse_frames(7);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        check_val("midchk_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
